accum_block: RTL and testbench
==============================

Name: accum_block

Overview:
- Parametrised block accumulator: accepts a stream of unsigned samples, each tagged with an operation.
- Adds, subtracts or holds each sample into a wide accumulator.
- Presents the block result on a valid/ready output once COUNT_MAX beats have been accepted, or on flush.
- Generalises the plain load/clear accumulator datapath with width parameters, operation modes, block counting, overflow reporting and flow control.

Parameters:
- WIDTH, 8, input sample width in bits (>=1).
- ACC_WIDTH, 16, accumulator and result width in bits (>=WIDTH).
- COUNT_MAX, 4, beats per block (>=1). CNT_W = $clog2(COUNT_MAX+1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  unsigned sample, zero-extended to ACC_WIDTH
- in_mode  input  2  operation for the beat: 00 CLR, 01 ADD, 10 SUB, 11 HOLD
- in_valid  input  1  beat offered
- in_ready  output  1  beat can be accepted
- flush  input  1  request early emit of a partial block
- out_data  output  ACC_WIDTH  accumulator register
- out_count  output  CNT_W  beats accumulated in current block
- out_ovf  output  1  sticky overflow/underflow flag for current block
- out_valid  output  1  result held for consumer
- out_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, rst_n=0): state=ACCUM; out_data=0, out_count=0, out_ovf=0, out_valid=0. Reset during EMIT discards the pending result.
- in_ready = (state==ACCUM), combinational from state only. Beat accepted when in_valid && in_ready.
- Accepted ADD: acc <= acc + in_data; count++.
- Accepted SUB: acc <= acc - in_data; count++.
- Accepted HOLD: acc unchanged; count++.
- Accepted CLR: acc, count and ovf all cleared to 0; no emit; a flush in the same cycle is ignored.
- ACCUM -> EMIT: on the edge where an accepted non-CLR beat makes count==COUNT_MAX.
  - out_valid=1 on the following cycle; latency 1 clock from the last beat.
- Flush (ACCUM only):
  - flush=1 and count>0 (or a non-CLR beat accepted the same cycle): go to EMIT. A same-cycle beat is included in the result.
  - flush with count==0 and no beat: ignored.
- EMIT:
  - in_ready=0; out_data, out_count and out_ovf are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: next cycle acc=0, count=0, ovf=0, out_valid=0, state=ACCUM.
  - No back-to-back bubble-free emit; minimum 1 idle ACCUM cycle between blocks.
  - flush in EMIT is ignored.
- Overflow: ADD with carry out of ACC_WIDTH, or SUB with borrow, sets out_ovf. It stays set until handoff, CLR or reset.
- out_data and out_count are visible, but not valid, during ACCUM.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- Defined: ADD clamps to 2^ACC_WIDTH-1 on overflow; SUB clamps to 0 on underflow. out_ovf is set as normal.
- Undefined: results wrap modulo 2^ACC_WIDTH; out_ovf is still set.
- Counting, handshake and timing are identical in both builds.

Test Plan:
- Reset with rst_n=0 mid-stream -> all outputs 0 asynchronously, in_ready=1 after release.
- ADD beats 10,20,30,40 (default params), out_ready=1 -> out_valid pulses 1 cycle after 4th beat; out_data=100, out_count=4, out_ovf=0; in_ready=0 for the EMIT cycle.
- Same block with out_ready held 0 for 5 cycles -> out_data=100 stable, in_ready=0, extra in_valid beats not accepted. Release out_ready -> acc cleared, next block starts from 0.
- ADD 5, SUB 10, flush -> emit with out_count=2, out_ovf=1. out_data=0xFFFB without the macro, 0x0000 with ACCUM_SATURATE_EN.
- ADD 7, HOLD, CLR asserted together with flush -> nothing emitted, out_data=0, out_count=0. A later flush with count 0 -> no out_valid.
- ADD 3 with flush in the same cycle -> emit out_data=3, out_count=1. ACC_WIDTH=8, WIDTH=8: ADD 200, ADD 100 -> 44 wrap (255 saturated), out_ovf=1.

Source files
------------

// File: rtl/accum_block.sv
// Block accumulator: ADD/SUB/HOLD/CLR beats into a wide accumulator, emitting on a full block or a flush.
// Optional macro ACCUM_SATURATE_EN clamps ADD/SUB results instead of wrapping.
module accum_block #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT_MAX = 4,
    localparam int CNT_W    = $clog2(COUNT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {ACCUM, EMIT} state_t;
    typedef enum logic [1:0] {MODE_CLR = 2'b00, MODE_ADD = 2'b01,
                              MODE_SUB = 2'b10, MODE_HOLD = 2'b11} mode_t;

    state_t                 state, next_state;
    logic [ACC_WIDTH-1:0]   acc, acc_d;
    logic [CNT_W-1:0]       count, count_d;
    logic                   ovf, ovf_d;
    logic                   accept;
    logic [ACC_WIDTH:0]     ext, sum, diff;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == EMIT);
    assign out_data  = acc;
    assign out_count = count;
    assign out_ovf   = ovf;
    assign accept    = in_valid && in_ready;

    // Extra top bit carries the ADD carry-out / SUB borrow.
    assign ext  = (ACC_WIDTH + 1)'(in_data);
    assign sum  = {1'b0, acc} + ext;
    assign diff = {1'b0, acc} - ext;

    always_comb begin
        next_state = state;
        acc_d      = acc;
        count_d    = count;
        ovf_d      = ovf;
        case (state)
            ACCUM: begin
                if (accept) begin
                    case (mode_t'(in_mode))
                        MODE_CLR: begin
                            acc_d   = '0;
                            count_d = '0;
                            ovf_d   = 1'b0;
                        end
                        MODE_ADD: begin
`ifdef ACCUM_SATURATE_EN
                            acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
                            acc_d = sum[ACC_WIDTH-1:0];
`endif
                            ovf_d   = ovf | sum[ACC_WIDTH];
                            count_d = count + CNT_W'(1);
                        end
                        MODE_SUB: begin
`ifdef ACCUM_SATURATE_EN
                            acc_d = diff[ACC_WIDTH] ? '0 : diff[ACC_WIDTH-1:0];
`else
                            acc_d = diff[ACC_WIDTH-1:0];
`endif
                            ovf_d   = ovf | diff[ACC_WIDTH];
                            count_d = count + CNT_W'(1);
                        end
                        default: count_d = count + CNT_W'(1);
                    endcase
                    if (in_mode != MODE_CLR &&
                        (count_d == CNT_W'(COUNT_MAX) || flush))
                        next_state = EMIT;
                end else if (flush && count != '0) begin
                    next_state = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    acc_d      = '0;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    next_state = ACCUM;
                end
            end
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= next_state;
            acc   <= acc_d;
            count <= count_d;
            ovf   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_accum_block.sv
// Directed self-checking bench for accum_block: default 16-bit build plus an 8-bit accumulator instance.
module tb_accum_block;

    localparam logic [1:0] CLR = 2'b00, ADD = 2'b01, SUB = 2'b10, HOLD = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_mode = ADD;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_count;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready = 1'b1;

    logic [7:0]  in_data8 = '0;
    logic [1:0]  in_mode8 = ADD;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  out_data8;
    logic [2:0]  out_count8;
    logic        out_ovf8;
    logic        out_valid8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    accum_block #(.WIDTH(8), .ACC_WIDTH(16), .COUNT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    accum_block #(.WIDTH(8), .ACC_WIDTH(8), .COUNT_MAX(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_mode(in_mode8),
        .in_valid(in_valid8), .in_ready(in_ready8), .flush(1'b0),
        .out_data(out_data8), .out_count(out_count8), .out_ovf(out_ovf8),
        .out_valid(out_valid8), .out_ready(1'b1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] mode, input logic [7:0] data, input logic fl);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        flush    = fl;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_data !== 16'd0 || out_count !== 3'd0 || out_ovf !== 1'b0 ||
            out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: data=%h cnt=%0d ovf=%b valid=%b ready=%b expected 0/0/0/0/1",
                     out_data, out_count, out_ovf, out_valid, in_ready);
        end
        beat(ADD, 8'd9, 1'b0);
        beat(ADD, 8'd9, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_data !== 16'd0 || out_count !== 3'd0 || out_ovf !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_midstream: data=%h cnt=%0d ovf=%b valid=%b expected all 0",
                     out_data, out_count, out_ovf, out_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
        end
        out_ready = 1'b0;
        beat(ADD, 8'd4, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_emit: out_valid=%b expected 1", out_valid);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_emit: valid=%b data=%h ready=%b expected 0/0000/1",
                     out_valid, out_data, in_ready);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_add_block();
        beat(ADD, 8'd10, 1'b0);
        beat(ADD, 8'd20, 1'b0);
        beat(ADD, 8'd30, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd60 || out_count !== 3'd3) begin
            failures++;
            $display("FAIL add_partial: valid=%b data=%0d cnt=%0d expected 0/60/3",
                     out_valid, out_data, out_count);
        end
        beat(ADD, 8'd40, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd100 || out_count !== 3'd4 ||
            out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_emit: valid=%b data=%0d cnt=%0d ovf=%b ready=%b expected 1/100/4/0/0",
                     out_valid, out_data, out_count, out_ovf, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_count !== 3'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_handoff: valid=%b data=%0d cnt=%0d ready=%b expected 0/0/0/1",
                     out_valid, out_data, out_count, in_ready);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(ADD, 8'd10, 1'b0);
        beat(ADD, 8'd20, 1'b0);
        beat(ADD, 8'd30, 1'b0);
        beat(ADD, 8'd40, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_mode  = ADD;
            in_data  = 8'd1;
            flush    = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd100 || out_count !== 3'd4 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%0d cnt=%0d ready=%b expected 1/100/4/0",
                         i, out_valid, out_data, out_count, in_ready);
            end
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_count !== 3'd0) begin
            failures++;
            $display("FAIL stall_release: valid=%b data=%0d cnt=%0d expected 0/0/0",
                     out_valid, out_data, out_count);
        end
        beat(ADD, 8'd5, 1'b0);
        checks++;
        if (out_data !== 16'd5 || out_count !== 3'd1) begin
            failures++;
            $display("FAIL stall_next_block: data=%0d cnt=%0d expected 5/1", out_data, out_count);
        end
        beat(CLR, 8'd0, 1'b0);
    endtask

    task automatic test_underflow();
        logic [15:0] exp_data;
`ifdef ACCUM_SATURATE_EN
        exp_data = 16'h0000;
`else
        exp_data = 16'hFFFB;
`endif
        out_ready = 1'b0;
        beat(ADD, 8'd5, 1'b0);
        beat(SUB, 8'd10, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_ovf !== 1'b1) begin
            failures++;
            $display("FAIL underflow_flag: valid=%b ovf=%b expected 0/1", out_valid, out_ovf);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd2 || out_ovf !== 1'b1 || out_data !== exp_data) begin
            failures++;
            $display("FAIL underflow_emit: valid=%b cnt=%0d ovf=%b data=%h expected 1/2/1/%h",
                     out_valid, out_count, out_ovf, out_data, exp_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_ovf !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear: ovf=%b valid=%b expected 0/0", out_ovf, out_valid);
        end
    endtask

    task automatic test_clr_flush();
        beat(ADD, 8'd7, 1'b0);
        beat(HOLD, 8'd99, 1'b0);
        checks++;
        if (out_data !== 16'd7 || out_count !== 3'd2) begin
            failures++;
            $display("FAIL hold_beat: data=%0d cnt=%0d expected 7/2", out_data, out_count);
        end
        beat(CLR, 8'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_count !== 3'd0) begin
            failures++;
            $display("FAIL clr_with_flush: valid=%b data=%0d cnt=%0d expected 0/0/0",
                     out_valid, out_data, out_count);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty: valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush_same_cycle();
        out_ready = 1'b0;
        beat(ADD, 8'd3, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd3 || out_count !== 3'd1) begin
            failures++;
            $display("FAIL flush_with_beat: valid=%b data=%0d cnt=%0d expected 1/3/1",
                     out_valid, out_data, out_count);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0) begin
            failures++;
            $display("FAIL flush_handoff: valid=%b data=%0d expected 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_wrap8();
        logic [7:0] exp_data;
`ifdef ACCUM_SATURATE_EN
        exp_data = 8'd255;
`else
        exp_data = 8'd44;
`endif
        in_valid8 = 1'b1;
        in_mode8  = ADD;
        in_data8  = 8'd200;
        step();
        in_data8  = 8'd100;
        step();
        in_valid8 = 1'b0;
        checks++;
        if (out_data8 !== exp_data || out_ovf8 !== 1'b1 || out_count8 !== 3'd2 || out_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL wrap8: data=%0d ovf=%b cnt=%0d valid=%b expected %0d/1/2/0",
                     out_data8, out_ovf8, out_count8, out_valid8, exp_data);
        end
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_add_block();
        test_backpressure();
        test_underflow();
        test_clr_flush();
        test_flush_same_cycle();
        test_wrap8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
